// File: rtl/vga_stream_capture.sv
// Receive-side VGA monitor: samples the pixel bus in the CLOCK_50 domain, rebuilds
// active-area coordinates, tracks frame lock and produces a per-frame colour checksum.
module vga_stream_capture #(
   parameter int WIDTH         = 640,
   parameter int HEIGHT        = 480,
   parameter int HS_ACTIVE_LOW = 1,
   parameter int VS_ACTIVE_LOW = 1
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        VGA_CLK,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        VGA_BLANK_N,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        geom_err,
   output logic [31:0] frame_sum,
   output logic        frame_sum_valid
);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   localparam logic [9:0] WIDTH_C  = 10'(WIDTH);
   localparam logic [8:0] HEIGHT_C = 9'(HEIGHT);
   localparam logic       HS_IDLE  = (HS_ACTIVE_LOW != 0);
   localparam logic       VS_IDLE  = (VS_ACTIVE_LOW != 0);

   logic        vga_clk_q, vga_clk_prev_q, vga_hs_q, vga_vs_q, vga_blank_n_q;
   logic [7:0]  vga_r_q, vga_g_q, vga_b_q;

   state_t      state_q, state_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [9:0]  xc_q, xc_d;
   logic [8:0]  yc_q, yc_d;
   logic        line_act_q, line_act_d;
   logic        line_err_q, line_err_d;
   logic        full_q, full_d;
   logic [31:0] acc_q, acc_d;

   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        pix_valid_q, pix_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        geom_err_q, geom_err_d;
   logic [31:0] frame_sum_q, frame_sum_d;
   logic        frame_sum_valid_q, frame_sum_valid_d;

   logic        pix_ev, hs_asrt, vs_asrt, hs_edge, vs_edge, act_pix, bad_pix;
   logic        line_err_now, frame_err_now;
   logic [8:0]  yc_h;
   logic [31:0] pix_sum;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         vga_clk_q      <= 1'b0;
         vga_clk_prev_q <= 1'b0;
         vga_hs_q       <= HS_IDLE;
         vga_vs_q       <= VS_IDLE;
         vga_blank_n_q  <= 1'b0;
         vga_r_q        <= '0;
         vga_g_q        <= '0;
         vga_b_q        <= '0;
      end else begin
         vga_clk_q      <= VGA_CLK;
         vga_clk_prev_q <= vga_clk_q;
         vga_hs_q       <= VGA_HS;
         vga_vs_q       <= VGA_VS;
         vga_blank_n_q  <= VGA_BLANK_N;
         vga_r_q        <= VGA_R;
         vga_g_q        <= VGA_G;
         vga_b_q        <= VGA_B;
      end
   end

   assign pix_ev  = vga_clk_q & ~vga_clk_prev_q;
   assign hs_asrt = HS_IDLE ? ~vga_hs_q : vga_hs_q;
   assign vs_asrt = VS_IDLE ? ~vga_vs_q : vga_vs_q;
   assign hs_edge = pix_ev & hs_asrt & ~hs_prev_q;
   assign vs_edge = pix_ev & vs_asrt & ~vs_prev_q;
   // Colour during sync is never a real pixel; it is flagged instead of counted.
   assign act_pix = pix_ev & vga_blank_n_q & ~hs_asrt & ~vs_asrt;
   assign bad_pix = pix_ev & vga_blank_n_q & (hs_asrt | vs_asrt);
   assign pix_sum = {22'd0, ({2'b00, vga_r_q} + {2'b00, vga_g_q} + {2'b00, vga_b_q})};

   always_comb begin
      state_d           = state_q;
      hs_prev_d         = hs_prev_q;
      vs_prev_d         = vs_prev_q;
      xc_d              = xc_q;
      yc_d              = yc_q;
      line_act_d        = line_act_q;
      line_err_d        = line_err_q;
      full_d            = full_q;
      acc_d             = acc_q;
      x_d               = x_q;
      y_d               = y_q;
      r_d               = r_q;
      g_d               = g_q;
      b_d               = b_q;
      pix_valid_d       = 1'b0;
      frame_start_d     = 1'b0;
      geom_err_d        = 1'b0;
      frame_sum_d       = frame_sum_q;
      frame_sum_valid_d = 1'b0;
      line_err_now      = 1'b0;
      frame_err_now     = 1'b0;
      yc_h              = yc_q;

      if (pix_ev) begin
         hs_prev_d = hs_asrt;
         vs_prev_d = vs_asrt;
         if (act_pix) begin
            if (state_q != SEARCH) begin
               pix_valid_d   = 1'b1;
               x_d           = xc_q;
               y_d           = yc_q;
               r_d           = vga_r_q;
               g_d           = vga_g_q;
               b_d           = vga_b_q;
               frame_start_d = (state_q == LOCKED) && (xc_q == '0) && (yc_q == '0);
            end
            acc_d      = acc_q + pix_sum;
            line_act_d = 1'b1;
            if (xc_q != '1) xc_d = xc_q + 10'd1;
         end
         if (bad_pix) line_err_now = 1'b1;
         // The HS side of a coincident HS/VS edge settles first so the frame check sees the final row count.
         if (hs_edge) begin
            if (line_act_q && (xc_q != WIDTH_C)) line_err_now = 1'b1;
            if (line_act_q && (yc_q != '1)) yc_h = yc_q + 9'd1;
            xc_d       = '0;
            line_act_d = 1'b0;
         end
         yc_d       = yc_h;
         line_err_d = line_err_q | line_err_now;
         if (vs_edge) begin
            frame_err_now = (yc_h != HEIGHT_C) || line_err_q || line_err_now;
            yc_d          = '0;
            line_err_d    = 1'b0;
            acc_d         = '0;
            if (full_q) begin
               frame_sum_d       = acc_q;
               frame_sum_valid_d = 1'b1;
            end
         end
      end

      unique case (state_q)
         SEARCH: begin
            if (vs_edge) begin
               state_d    = ALIGN;
               xc_d       = '0;
               yc_d       = '0;
               line_act_d = 1'b0;
               line_err_d = 1'b0;
            end
         end
         ALIGN: begin
            if (vs_edge && !frame_err_now) state_d = LOCKED;
         end
         LOCKED: begin
            if (line_err_now || frame_err_now) state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase

      geom_err_d = (state_q != SEARCH) && (line_err_now || frame_err_now);

      // A checksum is only published for frames spent entirely out of SEARCH.
      if (state_d == SEARCH) full_d = 1'b0;
      else if (vs_edge)      full_d = 1'b1;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= SEARCH;
         hs_prev_q         <= 1'b0;
         vs_prev_q         <= 1'b0;
         xc_q              <= '0;
         yc_q              <= '0;
         line_act_q        <= 1'b0;
         line_err_q        <= 1'b0;
         full_q            <= 1'b0;
         acc_q             <= '0;
         x_q               <= '0;
         y_q               <= '0;
         r_q               <= '0;
         g_q               <= '0;
         b_q               <= '0;
         pix_valid_q       <= 1'b0;
         frame_start_q     <= 1'b0;
         geom_err_q        <= 1'b0;
         frame_sum_q       <= '0;
         frame_sum_valid_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         hs_prev_q         <= hs_prev_d;
         vs_prev_q         <= vs_prev_d;
         xc_q              <= xc_d;
         yc_q              <= yc_d;
         line_act_q        <= line_act_d;
         line_err_q        <= line_err_d;
         full_q            <= full_d;
         acc_q             <= acc_d;
         x_q               <= x_d;
         y_q               <= y_d;
         r_q               <= r_d;
         g_q               <= g_d;
         b_q               <= b_d;
         pix_valid_q       <= pix_valid_d;
         frame_start_q     <= frame_start_d;
         geom_err_q        <= geom_err_d;
         frame_sum_q       <= frame_sum_d;
         frame_sum_valid_q <= frame_sum_valid_d;
      end
   end

   assign x               = x_q;
   assign y               = y_q;
   assign r               = r_q;
   assign g               = g_q;
   assign b               = b_q;
   assign pix_valid       = pix_valid_q;
   assign frame_start     = frame_start_q;
   assign locked          = (state_q == LOCKED);
   assign geom_err        = geom_err_q;
   assign frame_sum       = frame_sum_q;
   assign frame_sum_valid = frame_sum_valid_q;

endmodule

// File: tb/tb_vga_stream_capture.sv
// Directed bench for vga_stream_capture on a reduced 8x4 raster, with a second
// instance fed inverted syncs to cover active-high sync polarity.
module tb_vga_stream_capture;

   localparam int W = 8;
   localparam int H = 4;

   logic        CLOCK_50, reset_n, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        hs_inv, vs_inv;

   logic [9:0]  x, x_p;
   logic [8:0]  y, y_p;
   logic [7:0]  r, g, b, r_p, g_p, b_p;
   logic        pix_valid, frame_start, locked, geom_err, frame_sum_valid;
   logic        pix_valid_p, frame_start_p, locked_p, geom_err_p, frame_sum_valid_p;
   logic [31:0] frame_sum, frame_sum_p;

   assign hs_inv = ~VGA_HS;
   assign vs_inv = ~VGA_VS;

   vga_stream_capture #(.WIDTH(W), .HEIGHT(H), .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
      .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G),
      .VGA_B(VGA_B), .x(x), .y(y), .r(r), .g(g), .b(b), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked), .geom_err(geom_err),
      .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid));

   vga_stream_capture #(.WIDTH(W), .HEIGHT(H), .HS_ACTIVE_LOW(0), .VS_ACTIVE_LOW(0)) dut_p (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .VGA_CLK(VGA_CLK), .VGA_HS(hs_inv),
      .VGA_VS(vs_inv), .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G),
      .VGA_B(VGA_B), .x(x_p), .y(y_p), .r(r_p), .g(g_p), .b(b_p), .pix_valid(pix_valid_p),
      .frame_start(frame_start_p), .locked(locked_p), .geom_err(geom_err_p),
      .frame_sum(frame_sum_p), .frame_sum_valid(frame_sum_valid_p));

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Event counters and pixel scoreboard, sampled on the falling edge.
   int          n_pv = 0, n_fs = 0, n_ge = 0, n_fsv = 0;
   int          n_pv_p = 0, n_ge_p = 0;
   bit          sb_on = 1'b0;
   logic [42:0] sb_q[$];
   logic [42:0] sb_e;

   always @(negedge CLOCK_50) begin
      if (pix_valid) begin
         n_pv++;
         if (sb_on) begin
            if (sb_q.size() == 0) chk("sb_underrun", 64'd1, 64'd0);
            else begin
               sb_e = sb_q.pop_front();
               chk("pixel", {x, y, r, g, b}, sb_e);
            end
         end
      end
      if (frame_start)     n_fs++;
      if (geom_err)        n_ge++;
      if (frame_sum_valid) n_fsv++;
      if (pix_valid_p)     n_pv_p++;
      if (geom_err_p)      n_ge_p++;
   end

   int pv0, fs0, ge0, fsv0, pvp0;

   task automatic snap();
      pv0  = n_pv;
      fs0  = n_fs;
      ge0  = n_ge;
      fsv0 = n_fsv;
      pvp0 = n_pv_p;
   endtask

   // One pixel period: data changes with VGA_CLK low, VGA_CLK rises one CLOCK_50 later.
   task automatic pix(input bit hs, input bit vs, input bit de,
                      input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
      @(negedge CLOCK_50);
      VGA_CLK     = 1'b0;
      VGA_HS      = ~hs;
      VGA_VS      = ~vs;
      VGA_BLANK_N = de;
      VGA_R       = rr;
      VGA_G       = gg;
      VGA_B       = bb;
      @(negedge CLOCK_50);
      VGA_CLK     = 1'b1;
   endtask

   // Line: 2 HS pixels, 2 back porch, nact active, 2 front porch. mode 0 = constant colour.
   task automatic line(input bit vs, input int nact, input int row, input int mode);
      logic [7:0] rr, gg, bb;
      for (int i = 0; i < 2; i++) pix(1'b1, vs, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) pix(1'b0, vs, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int c = 0; c < nact; c++) begin
         if (mode == 1) begin
            rr = 8'h05;
            gg = 8'(c);
            bb = 8'(row);
            if (sb_on) sb_q.push_back({10'(c), 9'(row), rr, gg, bb});
         end else begin
            rr = 8'h10;
            gg = 8'h20;
            bb = 8'h30;
         end
         pix(1'b0, vs, 1'b1, rr, gg, bb);
      end
      for (int i = 0; i < 2; i++) pix(1'b0, vs, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   // Frame: VS line (edge coincides with HS edge), back porch line, active rows, front porch line.
   task automatic frame(input int nrows, input int mode);
      line(1'b1, 0, 0, mode);
      line(1'b0, 0, 0, mode);
      for (int rw = 0; rw < nrows; rw++) line(1'b0, W, rw, mode);
      line(1'b0, 0, 0, mode);
   endtask

   initial begin
      reset_n     = 1'b0;
      VGA_CLK     = 1'b0;
      VGA_HS      = 1'b1;
      VGA_VS      = 1'b1;
      VGA_BLANK_N = 1'b0;
      VGA_R       = 8'h00;
      VGA_G       = 8'h00;
      VGA_B       = 8'h00;
      repeat (4) @(negedge CLOCK_50);
      chk("rst_out", {x, y, r, g, b, pix_valid, frame_start, locked, geom_err, frame_sum_valid}, 64'd0);
      chk("rst_sum", frame_sum, 64'd0);
      chk("rst_out_p", {x_p, y_p, r_p, g_p, b_p, pix_valid_p, frame_start_p, locked_p, geom_err_p,
                        frame_sum_valid_p, frame_sum_p}, 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) pix(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

      // Constant colour: align on first VS edge, lock on the second.
      snap(); frame(H, 0);
      chk("s1_f1_locked", locked, 0);
      chk("s1_f1_locked_p", locked_p, 0);
      chk("s1_f1_pv", n_pv - pv0, 32);
      chk("s1_f1_pv_p", n_pv_p - pvp0, 32);
      chk("s1_f1_fsv", n_fsv - fsv0, 0);
      snap(); frame(H, 0);
      chk("s1_f2_locked", locked, 1);
      chk("s1_f2_locked_p", locked_p, 1);
      chk("s1_f2_fsv", n_fsv - fsv0, 1);
      chk("s1_f2_sum", frame_sum, 32'h0000_0C00);
      chk("s1_f2_fs", n_fs - fs0, 1);
      snap(); frame(H, 0);
      chk("s1_f3_sum", frame_sum, 32'h0000_0C00);
      chk("s1_f3_sum_p", frame_sum_p, 32'h0000_0C00);
      chk("s1_ge", n_ge, 0);

      // Coordinate pattern with per-pixel scoreboard.
      sb_on = 1'b1;
      snap(); frame(H, 1);
      chk("s2_f4_fs", n_fs - fs0, 1);
      chk("s2_f4_sum", frame_sum, 32'h0000_0C00);
      snap(); frame(H, 1);
      chk("s2_f5_fs", n_fs - fs0, 1);
      chk("s2_f5_sum", frame_sum, 32'h0000_0140);
      chk("s2_sb_left", sb_q.size(), 0);
      sb_on = 1'b0;
      chk("s2_ge", n_ge, 0);

      // Short line while locked: drop on the following HS edge, relock two VS edges later.
      snap();
      line(1'b1, 0, 0, 0);
      line(1'b0, 0, 0, 0);
      line(1'b0, W, 0, 0);
      line(1'b0, W, 1, 0);
      line(1'b0, W - 1, 2, 0);
      chk("s3_before_drop", locked, 1);
      line(1'b0, W, 3, 0);
      chk("s3_drop", locked, 0);
      chk("s3_ge", n_ge - ge0, 1);
      line(1'b0, 0, 0, 0);
      snap(); frame(H, 0);
      chk("s3_f7_locked", locked, 0);
      chk("s3_f7_fsv", n_fsv - fsv0, 0);
      snap(); frame(H, 0);
      chk("s3_f8_locked", locked, 1);
      chk("s3_f8_fsv", n_fsv - fsv0, 1);
      chk("s3_f8_ge", n_ge - ge0, 0);

      // One extra active line: error at the closing VS edge, sum still published.
      snap(); frame(H + 1, 0);
      chk("s4_f9_locked", locked, 1);
      chk("s4_f9_ge", n_ge - ge0, 0);
      snap(); frame(H, 0);
      chk("s4_f10_locked", locked, 0);
      chk("s4_f10_ge", n_ge - ge0, 1);
      chk("s4_f10_fsv", n_fsv - fsv0, 1);
      chk("s4_f10_sum", frame_sum, 32'h0000_0F00);
      frame(H, 0);
      frame(H, 0);
      chk("s4_relock", locked, 1);

      // Reset in the middle of a locked frame.
      line(1'b1, 0, 0, 0);
      line(1'b0, 0, 0, 0);
      line(1'b0, W, 0, 0);
      line(1'b0, W, 1, 0);
      chk("s5_pre_locked", locked, 1);
      chk("s5_pre_sum", frame_sum, 32'h0000_0C00);
      reset_n = 1'b0;
      snap();
      line(1'b0, W, 2, 0);
      chk("s5_rst_out", {x, y, r, g, b, pix_valid, frame_start, locked, geom_err, frame_sum_valid}, 64'd0);
      chk("s5_rst_sum", frame_sum, 64'd0);
      chk("s5_rst_pv", n_pv - pv0, 0);
      reset_n = 1'b1;
      line(1'b0, W, 3, 0);
      line(1'b0, 0, 0, 0);
      chk("s5_post_pv", n_pv - pv0, 0);
      chk("s5_post_locked", locked, 0);
      snap(); frame(H, 0);
      chk("s5_f14_locked", locked, 0);
      chk("s5_f14_pv", n_pv - pv0, 32);
      chk("s5_f14_fsv", n_fsv - fsv0, 0);
      snap(); frame(H, 0);
      chk("s5_f15_locked", locked, 1);
      chk("s5_f15_sum", frame_sum, 32'h0000_0C00);

      chk("ge_total", n_ge, 2);
      chk("ge_total_p", n_ge_p, 2);
      chk("end_locked_p", locked_p, 1);
      chk("end_sum_p", frame_sum_p, 32'h0000_0C00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
